// File: rtl/clk_div_multi.sv
// Multi-channel runtime-programmable clock divider with glitch-free registered
// clock outputs, end-of-period tick strobes and a global phase-align pulse.
module clk_div_multi #(
    parameter int NumChannels = 2,
    parameter int CntWidth    = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NumChannels-1:0]          en_i,
    input  logic                            sync_i,
    input  logic [NumChannels*CntWidth-1:0] div_i,
    output logic [NumChannels-1:0]          clk_o,
    output logic [NumChannels-1:0]          tick_o,
    output logic [NumChannels*CntWidth-1:0] cur_div_o
);

    localparam logic [CntWidth-1:0] MinDiv  = CntWidth'(2);
    localparam logic [CntWidth-1:0] OneCnt  = CntWidth'(1);
    localparam logic [CntWidth-1:0] ZeroCnt = CntWidth'(0);

    // Ratios below 2 cannot form a high and a low phase, so they clamp to 2.
    function automatic logic [CntWidth-1:0] sanitise(input logic [CntWidth-1:0] d);
        logic [CntWidth-1:0] r;
        if (d < MinDiv) begin
            r = MinDiv;
        end else begin
            r = d;
        end
        return r;
    endfunction

    for (genvar c = 0; c < NumChannels; c++) begin : g_ch
        logic [CntWidth-1:0] cnt_d, cnt_q;
        logic [CntWidth-1:0] div_d, div_q;
        logic                clk_d, clk_q;
        logic                tick_d, tick_q;
        logic                run_d, run_q;
        logic [CntWidth-1:0] req_s;
        logic [CntWidth-1:0] nxt_s;
        logic [CntWidth-1:0] last_s;

        assign req_s  = sanitise(div_i[c*CntWidth +: CntWidth]);
        assign nxt_s  = cnt_q + OneCnt;
        assign last_s = div_q - OneCnt;

        // Next position, output levels and applied ratio; priority is
        // disable, then restart (sync or first enabled edge), then counting.
        always_comb begin
            cnt_d  = cnt_q;
            div_d  = div_q;
            clk_d  = clk_q;
            tick_d = 1'b0;
            run_d  = run_q;
            if (!en_i[c]) begin
                cnt_d  = ZeroCnt;
                div_d  = req_s;
                clk_d  = 1'b0;
                tick_d = 1'b0;
                run_d  = 1'b0;
            end else if (sync_i || !run_q) begin
                // A ratio still at its reset value has never been loaded, so
                // the enable edge falls back to the requested ratio.
                cnt_d  = ZeroCnt;
                clk_d  = 1'b1;
                tick_d = 1'b0;
                run_d  = 1'b1;
                if (sync_i || (div_q < MinDiv)) begin
                    div_d = req_s;
                end else begin
                    div_d = div_q;
                end
            end else if (cnt_q == last_s) begin
                cnt_d  = ZeroCnt;
                div_d  = req_s;
                clk_d  = 1'b1;
                tick_d = 1'b0;
                run_d  = 1'b1;
            end else begin
                cnt_d  = nxt_s;
                div_d  = div_q;
                clk_d  = (nxt_s < (div_q >> 1));
                tick_d = (nxt_s == last_s);
                run_d  = 1'b1;
            end
        end

        // Channel state register; reset clears everything immediately.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q  <= ZeroCnt;
                div_q  <= ZeroCnt;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
                run_q  <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                div_q  <= div_d;
                clk_q  <= clk_d;
                tick_q <= tick_d;
                run_q  <= run_d;
            end
        end

        assign clk_o[c]                          = clk_q;
        assign tick_o[c]                         = tick_q;
        assign cur_div_o[c*CntWidth +: CntWidth] = div_q;
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: phase table plus hand-written corner
// sequences, with a cycle-level reference model feeding a scoreboard queue.
module tb_clk_div_multi;

    logic        clk;
    logic        rst_n;
    logic [1:0]  en_s;
    logic        sync_s;
    logic [15:0] div0_s;
    logic [15:0] div1_s;
    logic [31:0] div_s;
    logic [1:0]  clk_o_s;
    logic [1:0]  tick_o_s;
    logic [31:0] cur_s;

    assign div_s = {div1_s, div0_s};

    clk_div_multi #(.NumChannels(2), .CntWidth(16)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .en_i     (en_s),
        .sync_i   (sync_s),
        .div_i    (div_s),
        .clk_o    (clk_o_s),
        .tick_o   (tick_o_s),
        .cur_div_o(cur_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  clk;
        logic [1:0]  tick;
        logic [31:0] cur;
    } exp_t;

    typedef struct {
        logic [1:0]  en;
        logic [15:0] d0;
        logic [15:0] d1;
        logic        sync;
        int          cycles;
        logic [15:0] exp_cur0;
        logic [15:0] exp_cur1;
    } phase_t;

    exp_t   sb_q[$];
    phase_t tbl[5];
    int     n_chk;
    int     n_fail;

    int m_pos[2];
    int m_cur[2];
    bit m_run[2];
    bit m_clk[2];
    bit m_tick[2];

    logic rec_clk0[0:127];
    logic rec_clk1[0:127];
    logic rec_tick0[0:127];
    logic rec_tick1[0:127];
    logic [15:0] rec_cur0[0:127];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_pos[c] = 0; m_cur[c] = 0; m_run[c] = 0; m_clk[c] = 0; m_tick[c] = 0;
        end
    endtask

    // Advance the model on the inputs now driven, then compare after the edge.
    task automatic step(input int idx);
        exp_t e;
        exp_t got;
        for (int c = 0; c < 2; c++) begin
            int dv;
            int s;
            dv = (c == 0) ? int'(div0_s) : int'(div1_s);
            s  = (dv < 2) ? 2 : dv;
            if (!en_s[c]) begin
                m_run[c] = 0; m_pos[c] = 0; m_clk[c] = 0; m_tick[c] = 0; m_cur[c] = s;
            end else if (sync_s || !m_run[c]) begin
                if (sync_s || m_cur[c] < 2) m_cur[c] = s;
                m_run[c] = 1; m_pos[c] = 0; m_clk[c] = 1; m_tick[c] = 0;
            end else if (m_pos[c] == m_cur[c] - 1) begin
                m_pos[c] = 0; m_cur[c] = s; m_clk[c] = 1; m_tick[c] = 0;
            end else begin
                m_pos[c]  = m_pos[c] + 1;
                m_clk[c]  = (m_pos[c] < m_cur[c] / 2);
                m_tick[c] = (m_pos[c] == m_cur[c] - 1);
            end
        end
        e.clk  = {m_clk[1], m_clk[0]};
        e.tick = {m_tick[1], m_tick[0]};
        e.cur  = {m_cur[1][15:0], m_cur[0][15:0]};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = {clk_o_s, tick_o_s, cur_s};
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            chk("cycle", 64'(got), 64'(sb_q.pop_front()));
        end
        if (idx >= 0 && idx < 128) begin
            rec_clk0[idx]  = clk_o_s[0];
            rec_clk1[idx]  = clk_o_s[1];
            rec_tick0[idx] = tick_o_s[0];
            rec_tick1[idx] = tick_o_s[1];
            rec_cur0[idx]  = cur_s[15:0];
        end
    endtask

    // 25 high, 25 low, tick only in the last low cycle, for two periods.
    task automatic check_rtc(string tag);
        int hi;
        int tk;
        hi = 0; tk = 0;
        for (int i = 0; i < 25; i++) hi += int'(rec_clk0[i]);
        chk({tag, "_high25"}, 64'(hi), 64'd25);
        hi = 0;
        for (int i = 25; i < 50; i++) hi += int'(rec_clk0[i]);
        chk({tag, "_low25"}, 64'(hi), 64'd0);
        for (int i = 0; i < 100; i++) tk += int'(rec_tick0[i]);
        chk({tag, "_ticks"}, 64'(tk), 64'd2);
        chk({tag, "_tick49"}, 64'(rec_tick0[49]), 64'd1);
        chk({tag, "_tick99"}, 64'(rec_tick0[99]), 64'd1);
        chk({tag, "_cur"}, 64'(rec_cur0[60]), 64'd50);
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        rst_n = 1'b0; en_s = 2'b00; sync_s = 1'b0; div0_s = 16'd50; div1_s = 16'd5;
        model_reset();
        tbl[0] = '{2'b00, 16'd50, 16'd5,     1'b0, 3,   16'd50, 16'd5};
        tbl[1] = '{2'b11, 16'd50, 16'd5,     1'b0, 100, 16'd50, 16'd5};
        tbl[2] = '{2'b11, 16'd0,  16'd1,     1'b0, 10,  16'd2,  16'd2};
        tbl[3] = '{2'b00, 16'd8,  16'd65535, 1'b0, 2,   16'd8,  16'd65535};
        tbl[4] = '{2'b11, 16'd8,  16'd65535, 1'b0, 20,  16'd8,  16'd65535};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 64'({clk_o_s, tick_o_s, cur_s}), 64'd0);
        rst_n = 1'b1;

        for (int p = 0; p < 5; p++) begin
            en_s = tbl[p].en; div0_s = tbl[p].d0; div1_s = tbl[p].d1; sync_s = tbl[p].sync;
            for (int i = 0; i < tbl[p].cycles; i++) step(i);
            chk("phase_cur", 64'(cur_s), 64'({tbl[p].exp_cur1, tbl[p].exp_cur0}));
        end

        // RTC equivalence from a fresh enable.
        en_s = 2'b00; div0_s = 16'd50; div1_s = 16'd3;
        step(-1); step(-1);
        en_s = 2'b01;
        for (int i = 0; i < 100; i++) step(i);
        check_rtc("rtc");

        // Odd ratio 5: high 2, low 3.
        en_s = 2'b00; div0_s = 16'd5;
        step(-1); step(-1);
        en_s = 2'b01;
        for (int i = 0; i < 10; i++) step(i);
        chk("odd_pattern", 64'({rec_clk0[0], rec_clk0[1], rec_clk0[2], rec_clk0[3], rec_clk0[4]}),
            64'(5'b11000));
        chk("odd_tick", 64'({rec_tick0[3], rec_tick0[4], rec_tick0[9]}), 64'(3'b011));

        // Mid-period change 10 -> 4 at p=3.
        en_s = 2'b00; div0_s = 16'd10;
        step(-1); step(-1);
        en_s = 2'b01;
        for (int i = 0; i < 20; i++) begin
            step(i);
            if (i == 3) div0_s = 16'd4;
        end
        chk("mid_tick9", 64'({rec_tick0[8], rec_tick0[9]}), 64'(2'b01));
        chk("mid_cur_flip", 64'({rec_cur0[9], rec_cur0[10]}), 64'({16'd10, 16'd4}));
        chk("mid_new_period", 64'({rec_clk0[10], rec_clk0[11], rec_clk0[12], rec_clk0[13],
            rec_tick0[13], rec_tick0[17]}), 64'(6'b110011));

        // Sync alignment of ch0 div 6 and ch1 div 4 enabled 3 cycles apart.
        en_s = 2'b00; div0_s = 16'd6; div1_s = 16'd4;
        step(-1); step(-1);
        en_s = 2'b01;
        repeat (3) step(-1);
        en_s = 2'b11;
        repeat (4) step(-1);
        sync_s = 1'b1;
        step(0);
        sync_s = 1'b0;
        for (int i = 1; i < 8; i++) step(i);
        chk("sync_both_high", 64'({rec_clk0[0], rec_clk1[0], rec_tick0[0], rec_tick1[0]}),
            64'(4'b1100));
        chk("sync_tick_ch0", 64'({rec_tick0[4], rec_tick0[5]}), 64'(2'b01));
        chk("sync_tick_ch1", 64'({rec_tick1[2], rec_tick1[3]}), 64'(2'b01));

        // Disable while high, then re-enable with div 8.
        en_s = 2'b00; div0_s = 16'd8;
        step(-1); step(-1);
        en_s = 2'b01;
        step(-1); step(-1);
        en_s = 2'b00;
        step(0);
        chk("disable_low", 64'({rec_clk0[0], rec_tick0[0]}), 64'(2'b00));
        en_s = 2'b01;
        for (int i = 0; i < 8; i++) step(i);
        chk("reenable_pattern", 64'({rec_clk0[0], rec_clk0[1], rec_clk0[2], rec_clk0[3],
            rec_clk0[4], rec_clk0[5], rec_clk0[6], rec_clk0[7], rec_tick0[7]}), 64'(9'b111100001));

        // Asynchronous reset mid-period, then RTC behaviour from release.
        div0_s = 16'd50;
        en_s = 2'b01;
        repeat (10) step(-1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset", 64'({clk_o_s, tick_o_s, cur_s}), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) step(i);
        check_rtc("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
